// File: rtl/uart_frame_buffer.sv
// uart_frame_buffer
//   Collects bytes from a UART receiver into an inferred single-port RAM until
//   a frame closes (runtime length or optional terminator byte), then replays
//   the frame to a UART transmitter in forward or reverse order.
//
// Ports
//   sys_clk, sys_rst       : clock, asynchronous active-high reset
//   rx_valid, rx_data      : received byte strobe / data (from uart_rx)
//   frame_len              : bytes per frame; 0 or > DEPTH means DEPTH
//   term_en, term_char     : optional terminator that also closes the frame
//   reverse                : replay last-to-first, latched when the frame closes
//   tx_data, tx_start      : byte to send / one-cycle send request (to uart_tx)
//   tx_done                : transmitter finished the current byte
//   busy                   : high while replaying (not receiving)
//   fill_level             : bytes stored in the current frame
//   drop_cnt               : saturating count of bytes received while busy
module uart_frame_buffer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DROP_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              term_en,
  input  logic [DATA_W-1:0] term_char,
  input  logic              reverse,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              busy,
  output logic [ADDR_W:0]   fill_level,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int             DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] RECV = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   fill_q, fill_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              rev_q, rev_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_start_q;
  logic              busy_q;
  logic [DROP_W-1:0] drop_q;

  logic [ADDR_W:0]   eff_len, cnt_inc, len_m1;
  logic [ADDR_W-1:0] rd_addr, ram_addr;
  logic              close, last, ram_we;

  always_comb begin
    eff_len  = (frame_len == '0 || frame_len > DEPTH_L) ? DEPTH_L : frame_len;
    cnt_inc  = fill_q + 1'b1;
    // Close test uses the count including the byte being accepted now.
    close    = (cnt_inc >= eff_len) || (term_en && rx_data == term_char);
    len_m1   = len_q - 1'b1;
    last     = ({1'b0, idx_q} == len_m1);
    rd_addr  = rev_q ? ADDR_W'(len_m1 - {1'b0, idx_q}) : idx_q;
    // Single port: write address while receiving, replay address otherwise.
    ram_addr = (state_q == RECV) ? fill_q[ADDR_W-1:0] : rd_addr;
    ram_we   = (state_q == RECV) && rx_valid;
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    len_d   = len_q;
    rev_d   = rev_q;
    idx_d   = idx_q;
    case (state_q)
      RECV: if (rx_valid) begin
        fill_d = cnt_inc;
        if (close) begin
          len_d   = cnt_inc;
          rev_d   = reverse;
          state_d = RD;
        end
      end
      RD:   state_d = LOAD;
      LOAD: state_d = WAIT;
      WAIT: if (tx_done) begin
        if (last) begin
          idx_d   = '0;
          fill_d  = '0;
          state_d = RECV;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RD;
        end
      end
      default: state_d = RECV;
    endcase
  end

  // RAM array is not reset; contents are always overwritten before replay.
  always_ff @(posedge sys_clk) begin
    if (ram_we) mem[ram_addr] <= rx_data;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= RECV;
      fill_q     <= '0;
      len_q      <= '0;
      rev_q      <= 1'b0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      len_q   <= len_d;
      rev_q   <= rev_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d != RECV);
      // tx_data is the RAM read register: the read issued in RD lands during
      // LOAD together with the tx_start pulse, and holds until the next RD.
      if (state_q == RD) tx_data_q <= mem[ram_addr];
      tx_start_q <= (state_q == RD);
      if (rx_valid && state_q != RECV && drop_q != '1)
        drop_q <= drop_q + 1'b1;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign busy       = busy_q;
  assign fill_level = fill_q;
  assign drop_cnt   = drop_q;

endmodule

// File: doc/uart_frame_buffer.md
Name: uart_frame_buffer

Overview:
- Parametrised successor to the fixed 16-byte UART receive/replay buffer.
- Collects bytes from the UART receiver into internal inferred block RAM until a frame closes, then replays the frame to the UART transmitter.
- Frame closes on a runtime length or on an optional terminator byte.
- Replay is in forward or reverse order.
- Sits between uart_rx (rx_done/data) and uart_tx (send_en/tx_done) at top level.

Parameters:
- DATA_W, 8, byte width of rx/tx data and RAM word.
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W words (derived, not overridable).
- DROP_W, 8, width of the dropped-byte counter.

Ports:
- sys_clk  in  1  single system clock; all logic on rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse per received byte (from uart_rx rx_done).
- rx_data  in  DATA_W  received byte; valid with rx_valid.
- frame_len  in  ADDR_W+1  bytes per frame; 0 or >DEPTH treated as DEPTH.
- term_en  in  1  1 = terminator byte also closes the frame.
- term_char  in  DATA_W  terminator value.
- reverse  in  1  1 = replay last-to-first; sampled on RECV->RD transition.
- tx_data  out  DATA_W  byte to transmit; stable from tx_start until tx_done.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_done  in  1  one-cycle pulse from transmitter when a byte finishes.
- busy  out  1  1 while not in RECV.
- fill_level  out  ADDR_W+1  bytes stored in the current frame.
- drop_cnt  out  DROP_W  saturating count of bytes discarded.

Behaviour:
- Reset values (async, immediate):
  - state=RECV; fill_level=0; tx_data=0; tx_start=0; busy=0; drop_cnt=0.
  - Internal read index = 0. RAM contents are not reset.
- RAM: single port, synchronous write, synchronous read with 1-cycle latency.
- eff_len = DEPTH if frame_len==0 or frame_len>DEPTH, else frame_len. Evaluated every cycle.
- State RECV:
  - On rx_valid: write rx_data at address fill_level[ADDR_W-1:0]; fill_level += 1.
  - Close condition, evaluated on the same rx_valid using the incremented count: (count >= eff_len) or (term_en and rx_data==term_char).
  - On close: latch reverse and count into the replay length; next state RD.
  - The terminator byte is stored and replayed.
  - A frame always holds >=1 byte.
- State RD:
  - Drive RAM address = index (forward) or len-1-index (reverse); next state LOAD.
- State LOAD:
  - tx_data <= RAM output; tx_start pulses for exactly this one cycle; next state WAIT.
- State WAIT:
  - On tx_done: index += 1.
  - If index was len-1: index=0, fill_level=0, next state RECV.
  - Otherwise next state RD.
  - Latency from tx_done to next tx_start is 2 cycles.
- rx_valid in any state other than RECV: byte discarded, drop_cnt += 1, saturating at all-ones.
  - This includes the cycle in which the final tx_done arrives.
- tx_done outside WAIT is ignored.
- frame_len lowered mid-frame below fill_level: frame closes on the next accepted byte.
- busy = (state != RECV), registered alongside state.
- Reset asserted mid-replay aborts immediately; no further tx_start; the partial frame is discarded.

Test Plan:
- frame_len=4, term_en=0, reverse=0, send 0x11,0x22,0x33,0x44 -> exactly 4 tx_start pulses carrying 0x11,0x22,0x33,0x44; fill_level returns to 0; busy drops after 4th tx_done.
- frame_len=0 (DEPTH=16), send bytes 0x00..0x0F -> replay of 0x00..0x0F in order; no close before 16th byte.
- term_en=1, term_char=0x0A, frame_len=16, send 0x41,0x42,0x0A -> replay 0x41,0x42,0x0A; fill_level peaks at 3.
- reverse=1, frame_len=3, send 0xA0,0xB0,0xC0 -> replay 0xC0,0xB0,0xA0; toggling reverse mid-replay has no effect.
- During replay inject 3 rx_valid pulses, including one coincident with the final tx_done -> all discarded, drop_cnt=3; next frame stored from address 0. Preload drop_cnt to 0xFF (DROP_W=8) and inject a further drop -> drop_cnt stays 0xFF.
- Assert sys_rst during WAIT of byte 2 of 4 -> outputs at reset values within same cycle. After release, frame_len=2 and bytes 0x55,0x66 -> replay 0x55,0x66 only.
